// File: rtl/spi_frame_loader.sv
// spi_frame_loader: packs spi_slave bytes into pixels, loads the back
// bank of a dual-bank framebuffer and flips banks on complete frames.
module spi_frame_loader #(
  parameter int WIDTH     = 32,
  parameter int HEIGHT    = 16,
  parameter int BPP_BYTES = 3,
  parameter int ADDR_W    = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             data,
  input  logic                   valid,
  input  logic                   sot,
  input  logic                   eot,
  output logic                   wr_en,
  output logic                   wr_bank,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [BPP_BYTES*8-1:0] wr_data,
  output logic                   disp_bank,
  output logic                   flip_req,
  input  logic                   flip_ack,
  output logic                   frame_done,
  output logic                   err_short,
  output logic                   err_long,
  output logic                   err_busy,
  input  logic                   err_clr
);

  localparam int PW = BPP_BYTES * 8;
  localparam logic [ADDR_W:0] NPIX =
    (ADDR_W+1)'(WIDTH * HEIGHT);
  localparam logic [1:0] BLAST = 2'(BPP_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    FLIP_WAIT
  } state_t;

  state_t state, state_d;

  logic [ADDR_W:0]   addr_q, addr_d, seg_addr;
  logic [1:0]        bcnt_q, bcnt_d, seg_cnt;
  logic [PW-1:0]     pix_q, pix_d;
  logic              eot_q, eot_edge;
  logic              take, restart;
  logic              wr_en_d, wr_bank_d, disp_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [PW-1:0]     wr_data_d;
  logic              flip_d, done_d;
  logic              short_set, long_set, busy_set;

  assign eot_edge = eot & ~eot_q;

  always_comb begin
    state_d   = state;
    addr_d    = addr_q;
    bcnt_d    = bcnt_q;
    pix_d     = pix_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    wr_bank_d = wr_bank;
    disp_d    = disp_bank;
    flip_d    = flip_req;
    done_d    = 1'b0;
    short_set = 1'b0;
    long_set  = 1'b0;
    busy_set  = 1'b0;
    take      = 1'b0;
    restart   = 1'b0;
    seg_addr  = addr_q;
    seg_cnt   = bcnt_q;

    unique case (state)
      IDLE: begin
        if (valid && sot) begin
          take    = 1'b1;
          restart = 1'b1;
          state_d = RECV;
        end
      end
      RECV: begin
        if (valid && sot) begin
          take    = 1'b1;
          restart = 1'b1;
        end else if (valid && addr_q == NPIX) begin
          long_set = 1'b1;
        end else if (valid) begin
          take = 1'b1;
        end
      end
      FLIP_WAIT: begin
        busy_set = valid;
        if (flip_ack) begin
          disp_d    = ~disp_bank;
          wr_bank_d = ~wr_bank;
          flip_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      if (restart) begin
        seg_addr = '0;
        seg_cnt  = '0;
      end
      pix_d  = PW'({pix_q, data});
      addr_d = seg_addr;
      if (seg_cnt == BLAST) begin
        bcnt_d    = '0;
        wr_en_d   = 1'b1;
        wr_data_d = pix_d;
        wr_addr_d = seg_addr[ADDR_W-1:0];
        addr_d    = seg_addr + (ADDR_W+1)'(1);
      end else begin
        bcnt_d = seg_cnt + 2'd1;
      end
    end

    // End of transfer judges the address after this cycle's byte.
    if (state == RECV && eot_edge) begin
      if (addr_d == NPIX) begin
        flip_d  = 1'b1;
        state_d = FLIP_WAIT;
      end else begin
        short_set = 1'b1;
        state_d   = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      bcnt_q     <= '0;
      pix_q      <= '0;
      eot_q      <= 1'b1;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_bank    <= 1'b1;
      disp_bank  <= 1'b0;
      flip_req   <= 1'b0;
      frame_done <= 1'b0;
      err_short  <= 1'b0;
      err_long   <= 1'b0;
      err_busy   <= 1'b0;
    end else begin
      state      <= state_d;
      addr_q     <= addr_d;
      bcnt_q     <= bcnt_d;
      pix_q      <= pix_d;
      eot_q      <= eot;
      wr_en      <= wr_en_d;
      wr_addr    <= wr_addr_d;
      wr_data    <= wr_data_d;
      wr_bank    <= wr_bank_d;
      disp_bank  <= disp_d;
      flip_req   <= flip_d;
      frame_done <= done_d;
      err_short  <= short_set | (err_short & ~err_clr);
      err_long   <= long_set | (err_long & ~err_clr);
      err_busy   <= busy_set | (err_busy & ~err_clr);
    end
  end

endmodule

// File: tb/tb_spi_frame_loader.sv
// tb_spi_frame_loader: random byte streams against a frame-level
// model; expected writes are queued and checked by a monitor.
module tb_spi_frame_loader;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int B  = 3;
  localparam int AW = 9;
  localparam int N  = W * H;
  localparam int PW = B * 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    data = '0;
  logic          valid = 1'b0;
  logic          sot = 1'b0;
  logic          eot = 1'b1;
  logic          wr_en, wr_bank, disp_bank;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] wr_data;
  logic          flip_req, frame_done;
  logic          flip_ack = 1'b0;
  logic          err_short, err_long, err_busy;
  logic          err_clr = 1'b0;

  spi_frame_loader #(
    .WIDTH(W), .HEIGHT(H), .BPP_BYTES(B), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .data(data), .valid(valid),
    .sot(sot), .eot(eot), .wr_en(wr_en), .wr_bank(wr_bank),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .disp_bank(disp_bank), .flip_req(flip_req),
    .flip_ack(flip_ack), .frame_done(frame_done),
    .err_short(err_short), .err_long(err_long),
    .err_busy(err_busy), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          bank;
    logic [AW-1:0] addr;
    logic [PW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  bit m_disp  = 1'b0;
  bit m_flip  = 1'b0;
  bit m_short = 1'b0;
  bit m_long  = 1'b0;
  bit m_busy  = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  logic vprev = 1'b0;
  always @(negedge clk) begin
    if (rst && wr_en) begin
      wr_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write bank=%0d addr=%0d data=%h",
                 wr_bank, wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({wr_bank, wr_addr, wr_data} !== e || !vprev) begin
          errors++;
          $display("FAIL write actual=%0d/%0d/%h expected=%0d/%0d/%h lat_ok=%0d",
                   wr_bank, wr_addr, wr_data, e.bank, e.addr, e.data,
                   vprev);
        end
      end
    end
    vprev = valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame-level model of one sot-delimited byte segment.
  task automatic model_seg(input logic [7:0] s[$], input bit fin);
    int len = s.size();
    int np = len / B;
    if (np > N) np = N;
    if (len > N * B) m_long = 1'b1;
    for (int p = 0; p < np; p++) begin
      wr_t e;
      logic [PW-1:0] d = '0;
      for (int k = 0; k < B; k++)
        d = (d << 8) | PW'(s[p*B+k]);
      e.bank = ~m_disp;
      e.addr = AW'(p);
      e.data = d;
      exp_q.push_back(e);
    end
    if (fin) begin
      if (len >= N * B) m_flip = 1'b1;
      else m_short = 1'b1;
    end
  endtask

  task automatic send(input logic [7:0] b, input bit s, input bit e);
    data  = b;
    valid = 1'b1;
    sot   = s;
    if (e) eot = 1'b1;
    tick();
    valid = 1'b0;
    sot   = 1'b0;
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic check_state(input string nm);
    chk({nm, "_drain"}, 64'(exp_q.size()), 64'd0);
    chk({nm, "_err"}, {err_short, err_long, err_busy},
        {m_short, m_long, m_busy});
    chk({nm, "_bank"}, {disp_bank, wr_bank, flip_req},
        {m_disp, ~m_disp, m_flip});
  endtask

  task automatic xfer(input int n1, input int n2, input bit same);
    logic [7:0] s1[$];
    logic [7:0] s2[$];
    for (int i = 0; i < n1; i++) s1.push_back(8'($urandom));
    for (int i = 0; i < n2; i++) s2.push_back(8'($urandom));
    if (m_flip) begin
      if (n1 + n2 > 0) m_busy = 1'b1;
    end else begin
      if (n1 > 0) model_seg(s1, n2 == 0);
      if (n2 > 0) model_seg(s2, 1'b1);
    end
    eot = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < n1; i++)
      send(s1[i], i == 0, same && n2 == 0 && i == n1 - 1);
    for (int i = 0; i < n2; i++)
      send(s2[i], i == 0, same && i == n2 - 1);
    eot = 1'b1;
    repeat (3) tick();
    check_state("xfer");
  endtask

  task automatic ack(input int dly);
    bit was;
    repeat (dly) tick();
    was = m_flip;
    chk("flip_req_before_ack", flip_req, m_flip);
    flip_ack = 1'b1;
    tick();
    flip_ack = 1'b0;
    if (was) m_disp = ~m_disp;
    m_flip = 1'b0;
    chk("frame_done", frame_done, was);
    chk("ack_bank", {disp_bank, wr_bank, flip_req},
        {m_disp, ~m_disp, 1'b0});
    tick();
    chk("frame_done_pulse", frame_done, 1'b0);
  endtask

  task automatic clear();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    m_short = 1'b0;
    m_long  = 1'b0;
    m_busy  = 1'b0;
    chk("err_clr", {err_short, err_long, err_busy}, 3'b000);
  endtask

  initial begin
    logic [7:0] s[$];
    repeat (3) tick();
    chk("reset_vals",
        {wr_en, wr_bank, wr_addr, wr_data, disp_bank, flip_req,
         frame_done, err_short, err_long, err_busy},
        {1'b0, 1'b1, AW'(0), PW'(0), 1'b0, 1'b0,
         1'b0, 3'b000});
    rst = 1'b1;
    repeat (2) tick();

    xfer(24, 0, 1'b0);
    ack(5);
    xfer(12, 0, 1'b0);
    ack(1);
    clear();
    xfer(27, 0, 1'b0);
    ack(2);
    clear();
    xfer(24, 0, 1'b1);
    xfer(4, 0, 1'b0);
    ack(3);
    clear();
    xfer(24, 0, 1'b0);
    ack(0);
    xfer(10, 24, 1'b0);
    ack(4);

    for (int it = 0; it < 30; it++) begin
      int r  = $urandom_range(0, 3);
      int n1 = 24;
      int n2 = 0;
      case (r)
        1: n1 = $urandom_range(1, 23);
        2: n1 = $urandom_range(25, 30);
        3: begin
          n1 = $urandom_range(1, 12);
          n2 = $urandom_range(20, 28);
        end
        default: n1 = 24;
      endcase
      xfer(n1, n2, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) != 0) ack($urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) clear();
    end
    ack(1);
    clear();

    // Mid-frame reset after five pixels.
    for (int i = 0; i < 5 * B; i++) s.push_back(8'($urandom));
    model_seg(s, 1'b0);
    eot = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 5 * B; i++) send(s[i], i == 0, 1'b0);
    repeat (2) tick();
    chk("pre_reset_drain", 64'(exp_q.size()), 64'd0);
    #2 rst = 1'b0;
    #1;
    chk("async_reset",
        {wr_en, wr_bank, wr_addr, wr_data, disp_bank, flip_req,
         frame_done, err_short, err_long, err_busy},
        {1'b0, 1'b1, AW'(0), PW'(0), 1'b0, 1'b0,
         1'b0, 3'b000});
    m_disp = 1'b0;
    m_flip = 1'b0;
    tick();
    rst = 1'b1;
    eot = 1'b1;
    repeat (2) tick();
    xfer(24, 0, 1'b0);
    ack(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
